// File: rtl/insertion_sort_stream.sv
// insertion_sort_stream: streaming insertion sorter with argsort output.
//
// Elements arrive one per cycle (i_valid/o_ready) and are inserted into a sorted register file
// in a single cycle using a parallel compare-and-shift. Once a frame closes (i_last, or the
// slot file is full), the sorted frame drains in order (o_valid/i_ready) with each value's
// arrival index.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clear        synchronous abort of the current frame (beats any same-cycle handshake)
//   i_desc         sort order (1 = descending), captured with the first element of a frame
//   i_valid, i_data, i_last, o_ready    input element stream
//   o_valid, o_data, o_idx, o_last, i_ready  sorted output stream
//   o_count        number of elements held in the current frame
module insertion_sort_stream #(
  parameter int unsigned SIZE_DATA  = 8,
  parameter int unsigned NUMBER_ARR = 8,
  parameter bit          SIGNED     = 1'b0,
  localparam int unsigned IDX_W     = $clog2(NUMBER_ARR),
  localparam int unsigned CNT_W     = $clog2(NUMBER_ARR + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_desc,
  input  logic                 i_valid,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_data,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic [CNT_W-1:0]     o_count
);

  typedef enum logic {StFill, StDrain} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 desc_q, desc_d;
  logic [SIZE_DATA-1:0] data_q [NUMBER_ARR];
  logic [SIZE_DATA-1:0] data_d [NUMBER_ARR];
  logic [IDX_W-1:0]     idx_q  [NUMBER_ARR];
  logic [IDX_W-1:0]     idx_d  [NUMBER_ARR];

  // Slots at or after the insert position: occupied slots that compare strictly past the new
  // element, plus the first free slot. Because the file is sorted this is a contiguous run.
  logic [NUMBER_ARR-1:0] ge;

  function automatic logic greater(input logic [SIZE_DATA-1:0] a, input logic [SIZE_DATA-1:0] b);
    if (SIGNED) begin
      return $signed(a) > $signed(b);
    end
    return a > b;
  endfunction

  always_comb begin
    ge = '0;
    for (int unsigned k = 0; k < NUMBER_ARR; k++) begin
      if (CNT_W'(k) < cnt_q) begin
        ge[k] = desc_q ? greater(i_data, data_q[k]) : greater(data_q[k], i_data);
      end else if (CNT_W'(k) == cnt_q) begin
        ge[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    desc_d   = desc_q;
    data_d   = data_q;
    idx_d    = idx_q;

    if (i_clear) begin
      state_d  = StFill;
      cnt_d    = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (i_valid) begin
            // Slot 0 can only receive the new element; higher slots take their lower
            // neighbour when the insert point lies below them.
            if (ge[0]) begin
              data_d[0] = i_data;
              idx_d[0]  = cnt_q[IDX_W-1:0];
            end
            for (int unsigned k = 1; k < NUMBER_ARR; k++) begin
              if (ge[k]) begin
                if (ge[k-1]) begin
                  data_d[k] = data_q[k-1];
                  idx_d[k]  = idx_q[k-1];
                end else begin
                  data_d[k] = i_data;
                  idx_d[k]  = cnt_q[IDX_W-1:0];
                end
              end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) begin
              desc_d = i_desc;
            end
            if (i_last || (cnt_q == CNT_W'(NUMBER_ARR - 1))) begin
              state_d  = StDrain;
              rd_ptr_d = '0;
            end
          end
        end
        StDrain: begin
          if (i_ready) begin
            if (rd_ptr_q == cnt_q - 1'b1) begin
              state_d  = StFill;
              cnt_d    = '0;
              rd_ptr_d = '0;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StFill;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      desc_q   <= 1'b0;
      for (int unsigned k = 0; k < NUMBER_ARR; k++) begin
        data_q[k] <= '0;
        idx_q[k]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      desc_q   <= desc_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
    end
  end

  // All outputs come from registered state only.
  always_comb begin
    o_ready = (state_q == StFill);
    o_valid = (state_q == StDrain);
    o_data  = data_q[rd_ptr_q[IDX_W-1:0]];
    o_idx   = idx_q[rd_ptr_q[IDX_W-1:0]];
    o_last  = (state_q == StDrain) && (rd_ptr_q == cnt_q - 1'b1);
    o_count = cnt_q;
  end

endmodule

// File: tb/tb_insertion_sort_stream.sv
// Self-checking bench for insertion_sort_stream: an unsigned and a signed instance share all
// inputs; a reference model computes each frame's stable sort and pushes it per instance.
module tb_insertion_sort_stream;
  localparam int N = 8;

  typedef struct {
    logic [7:0] data;
    logic [2:0] idx;
    logic       last;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, clr, desc, ivalid, ilast, iready;
  logic [7:0] idata;
  logic       ordy [2];
  logic       ovld [2];
  logic       olast[2];
  logic [7:0] odata[2];
  logic [2:0] oidx [2];
  logic [3:0] ocnt [2];

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic       stall  [2];
  logic       exp_rdy[2];
  logic [7:0] hd[2];
  logic [2:0] hi[2];
  logic       hl[2];
  logic       bp_en = 1'b0;

  always #5 clk = ~clk;

  insertion_sort_stream #(.SIZE_DATA(8), .NUMBER_ARR(N), .SIGNED(1'b0)) u_dut_u (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_desc(desc), .i_valid(ivalid), .i_data(idata),
    .i_last(ilast), .o_ready(ordy[0]), .o_valid(ovld[0]), .o_data(odata[0]), .o_idx(oidx[0]),
    .o_last(olast[0]), .i_ready(iready), .o_count(ocnt[0])
  );

  insertion_sort_stream #(.SIZE_DATA(8), .NUMBER_ARR(N), .SIGNED(1'b1)) u_dut_s (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_desc(desc), .i_valid(ivalid), .i_data(idata),
    .i_last(ilast), .o_ready(ordy[1]), .o_valid(ovld[1]), .o_data(odata[1]), .o_idx(oidx[1]),
    .o_last(olast[1]), .i_ready(iready), .o_count(ocnt[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // a strictly precedes b in the requested order
  function automatic bit prec(input logic [7:0] a, input logic [7:0] b, input bit d, input bit sg);
    int ia, ib;
    ia = sg ? int'($signed(a)) : int'(a);
    ib = sg ? int'($signed(b)) : int'(b);
    return d ? (ia > ib) : (ia < ib);
  endfunction

  // Rank-based stable sort: position = elements strictly ahead + equal elements arriving earlier.
  task automatic push_frame(input int n, input logic [7:0] v[N], input bit d);
    exp_t arr[N];
    for (int sg = 0; sg < 2; sg++) begin
      for (int i = 0; i < n; i++) begin
        int pos = 0;
        for (int j = 0; j < n; j++) begin
          if (j != i && (prec(v[j], v[i], d, sg[0]) || (v[j] == v[i] && j < i))) pos++;
        end
        arr[pos].data = v[i];
        arr[pos].idx  = 3'(i);
        arr[pos].last = (pos == n - 1);
        arr[pos].cnt  = 4'(n);
      end
      for (int p = 0; p < n; p++) begin
        if (sg == 0) q0.push_back(arr[p]);
        else q1.push_back(arr[p]);
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ready"}, ordy[d], 1);
      chk({tag, "_valid"}, ovld[d], 0);
      chk({tag, "_data"},  odata[d], 0);
      chk({tag, "_idx"},   oidx[d], 0);
      chk({tag, "_last"},  olast[d], 0);
      chk({tag, "_count"}, ocnt[d], 0);
    end
  endtask

  // Called at posedge+1. Leaves the bench at posedge+1 after the last accept.
  task automatic send_frame(input int n, input logic [7:0] v[N], input bit d, input bit use_last);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (!ordy[0] && k < 300) begin
        @(posedge clk); #1; k++;
      end
      chk("ready_wait", ordy[0], 1);
      ivalid = 1'b1;
      idata  = v[i];
      desc   = (i == 0) ? d : ~d;  // later elements must not change the captured order
      ilast  = use_last && (i == n - 1);
      if (i == n - 1 && (use_last || n == N)) push_frame(n, v, d);
      @(posedge clk); #1;
      ivalid = 1'b0;
      ilast  = 1'b0;
      for (int dd = 0; dd < 2; dd++) begin
        chk("count", ocnt[dd], 32'(i + 1));
        if (i == n - 1 && (use_last || n == N)) chk("valid_latency", ovld[dd], 1);
      end
    end
  endtask

  task automatic wait_drain(input bit junk);
    int k = 0;
    while (k < 300 && !(q0.size() == 0 && q1.size() == 0 && ordy[0])) begin
      if (junk) begin
        ivalid = 1'b1; idata = 8'hEE; ilast = 1'b1;
      end
      @(posedge clk); #1; k++;
    end
    ivalid = 1'b0;
    ilast  = 1'b0;
    chk("drain_done", 32'(k < 300), 1);
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (exp_rdy[d]) begin
      chk("ready_after_last", ordy[d], 1);
      chk("valid_after_last", ovld[d], 0);
      exp_rdy[d] = 1'b0;
    end
    if (stall[d]) begin
      chk("stall_valid", ovld[d], 1);
      chk("stall_data", odata[d], hd[d]);
      chk("stall_idx", oidx[d], hi[d]);
      chk("stall_last", olast[d], hl[d]);
      stall[d] = 1'b0;
    end
    if (ovld[d]) begin
      chk("ready_in_drain", ordy[d], 0);
      if (!clr) begin
        if (iready) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk("unexpected_out", ovld[d], 0);
          end else begin
            if (d == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk(d == 0 ? "u_data" : "s_data", odata[d], e.data);
            chk(d == 0 ? "u_idx" : "s_idx", oidx[d], e.idx);
            chk(d == 0 ? "u_last" : "s_last", olast[d], e.last);
            chk(d == 0 ? "u_count" : "s_count", ocnt[d], e.cnt);
            if (e.last) exp_rdy[d] = 1'b1;
          end
        end else begin
          stall[d] = 1'b1;
          hd[d] = odata[d];
          hi[d] = oidx[d];
          hl[d] = olast[d];
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  // Output backpressure pattern 1,0,0,1 when enabled.
  initial begin
    int bp_i = 0;
    logic [3:0] pat = 4'b1001;
    iready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_en) begin
        iready = pat[bp_i];
        bp_i   = (bp_i + 1) % 4;
      end else begin
        iready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v[N];
    rst = 1'b1; clr = 1'b0; desc = 1'b0; ivalid = 1'b0; ilast = 1'b0; idata = '0;
    for (int d = 0; d < 2; d++) begin
      stall[d] = 1'b0; exp_rdy[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Ascending full frame, no i_last.
    v = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
    send_frame(8, v, 1'b0, 1'b0);
    wait_drain(1'b0);

    // Descending short frame with duplicates.
    v = '{8'd4, 8'd9, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(3, v, 1'b1, 1'b1);
    wait_drain(1'b0);

    // Signed vs unsigned ordering.
    v = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h0, 8'h0, 8'h0, 8'h0};
    send_frame(4, v, 1'b0, 1'b1);
    wait_drain(1'b0);

    // Backpressure with junk presented during drain.
    bp_en = 1'b1;
    v = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
    send_frame(8, v, 1'b0, 1'b0);
    wait_drain(1'b1);
    bp_en = 1'b0;
    @(posedge clk); #1;

    // Clear after 3 accepts, coincident with a 4th element.
    v = '{8'd30, 8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(3, v, 1'b0, 1'b0);
    clr = 1'b1; ivalid = 1'b1; idata = 8'd1;
    @(posedge clk); #1;
    clr = 1'b0; ivalid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("clear_count", ocnt[d], 0);
      chk("clear_ready", ordy[d], 1);
      chk("clear_valid", ovld[d], 0);
    end
    v = '{8'h20, 8'h10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(2, v, 1'b0, 1'b1);
    wait_drain(1'b0);

    // Reset during drain.
    v = '{8'd50, 8'd40, 8'd60, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(4, v, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset("midreset");
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      stall[d] = 1'b0; exp_rdy[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-element frame then an immediate back-to-back ascending frame.
    v = '{8'h42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(1, v, 1'b1, 1'b1);
    wait_drain(1'b0);
    v = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(3, v, 1'b0, 1'b1);
    wait_drain(1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/insertion_sort_stream.md
# insertion_sort_stream

Streaming, parametrised successor to the team's load-all insertion sorter. Elements arrive one per cycle over a valid/ready handshake and are inserted into a sorted register file in a single cycle each, using a parallel compare-and-shift across all slots. The sorted frame is then drained in order over a second valid/ready handshake, with each value's original arrival index. The block sits between a producer stream and any consumer that needs ordered data or an argsort.

## Interface
- SIZE_DATA, 8, element width in bits
- NUMBER_ARR, 8, maximum elements per frame (≥2)
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare
- (derived) IDX_W = $clog2(NUMBER_ARR), CNT_W = $clog2(NUMBER_ARR+1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous and active-high
- i_clear  in  1  synchronous abort; discards the current frame
- i_desc  in  1  sort order; 0 = ascending, 1 = descending; captured with the first element of a frame
- i_valid  in  1  input element valid
- i_data  in  SIZE_DATA  input element
- i_last  in  1  marks the final element of the frame
- o_ready  out  1  block accepts an input element this cycle
- o_valid  out  1  output element valid
- o_data  out  SIZE_DATA  sorted element
- o_idx  out  IDX_W  arrival index (0-based) of o_data within its frame
- o_last  out  1  final output element of the frame
- i_ready  in  1  consumer accepts the output element
- o_count  out  CNT_W  number of elements held in the current frame

## Operation
- States: FILL, DRAIN. Reset enters FILL.
- FILL:
  - o_ready=1, o_valid=0.
  - Accept = i_valid & o_ready.
  - On each accept, all slots k < count compare against i_data in parallel.
  - Ascending: the insert position p is the first slot with slot[k] > i_data (strict); descending: the first slot with slot[k] < i_data (strict); otherwise p = count.
  - Slots p..count-1 shift up by one. Slot p receives {i_data, idx=count}. count increments.
  - Strict compare makes the sort stable: equal values keep arrival order.
  - i_desc is registered on the accept where count==0 and held for the whole frame.
- Frame close: an accept with i_last=1, or the accept that makes count==NUMBER_ARR. Either one moves to DRAIN and resets rd_ptr to 0.
  - At the NUMBER_ARR limit, a missing i_last is not an error. The next element starts a new frame.
- DRAIN:
  - o_ready=0 and i_valid is ignored.
  - o_valid=1; o_data and o_idx come from slot[rd_ptr]; o_last = (rd_ptr==count-1).
  - On o_valid & i_ready, rd_ptr increments. The handshake with o_last=1 sets count to 0 and returns to FILL.
- i_clear:
  - In either state: count←0, rd_ptr←0, state←FILL. Slot contents are don't-care.
  - i_clear has priority over a same-cycle accept or output handshake; that element or handshake is discarded.
- Arithmetic:
  - The compare is signed or unsigned per SIGNED.
  - count and rd_ptr never exceed NUMBER_ARR and never wrap.
  - o_idx < NUMBER_ARR always.

## Timing
- Reset values: o_ready=1, o_valid=0, o_data=0, o_idx=0, o_last=0, o_count=0. All slots are 0 and the stored desc flag is 0.
- Reset asserted mid-frame or mid-drain aborts immediately, with no partial output.
- o_ready, o_valid and o_last are decoded from registered state only. There is no combinational path from i_valid or i_ready to any output.
- Insert latency: an element accepted at edge t is visible in its slot and in o_count after edge t.
- Frame latency:
  - If the closing element is accepted at edge t, o_valid is high in the cycle after t, with the first sorted element.
  - Drain throughput is 1 element per cycle while i_ready=1.
  - A frame of N elements occupies N fill cycles plus N drain cycles, with no overlap.
- Back-to-back frames: o_ready rises in the cycle after the o_last handshake.
- While o_valid=1 and i_ready=0, o_data, o_idx and o_last hold stable.

## Test plan
- Ascending full frame, unsigned: 8 inputs 5,3,7,1,8,2,6,4 with no i_last. Required: o_data 1..8; o_idx 3,5,1,7,0,6,2,4; o_last only on 8; o_valid in the cycle after the 8th accept.
- Descending short frame with duplicates: i_desc=1; 3 inputs 4,9,4, i_last on the third. Required: o_data 9,4,4; o_idx 1,0,2 (stable); o_count=3.
- Signed mode: SIGNED=1, SIZE_DATA=8; inputs 0x7F,0x80,0x00,0xFF, ascending. Required: o_data 0x80,0xFF,0x00,0x7F.
- Backpressure: the frame from the first scenario, with i_ready toggled 1,0,0,1,… Required: outputs stable during stalls, order unchanged, o_ready=0 throughout drain, inputs presented during drain ignored.
- Clear and reset mid-operation:
  - i_clear after 3 accepts, coincident with a 4th i_valid. Required: o_count=0 next cycle, 4th element discarded, the next 2-element frame sorts correctly.
  - i_rst asserted during drain. Required: all outputs at reset values immediately.
- Single-element frame and back-to-back frames: input 0x42 with i_last. Required: one output, o_idx=0, o_last=1; o_ready high in the cycle after that handshake; a second frame immediately after is correct with no carry-over of i_desc.
